// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences one shared ALU and a unified
// instruction/data memory, driving every datapath select and write enable.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   opcode, funct3  latched instruction fields from the IR
//   funct7b5        instruction bit 30 (sub / sra select)
//   Z               ALU zero flag, used by beq
//   PC_write        PC load enable
//   adr_sel         memory address: 0 = PC, 1 = ALUOut
//   IR_write        IR and old_PC load enable
//   mem_wren        memory write enable
//   regfile_wren    register file write enable
//   ALU_asel        00 PC, 01 old_PC, 10 register A
//   ALU_bsel        00 register B, 01 ximm, 10 constant 4
//   result_sel      00 ALUOut, 01 data register, 10 ALU_result
//   ALU_control     ALU operation code
//   ximm_sel        immediate format: 00 I, 01 S, 10 B, 11 J
//   instr_done      pulse in the last cycle of a retired instruction
//   illegal_instr   pulse in DECODE for an unsupported opcode
module multicycle_control #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Z,
  output logic       PC_write,
  output logic       adr_sel,
  output logic       IR_write,
  output logic       mem_wren,
  output logic       regfile_wren,
  output logic [1:0] ALU_asel,
  output logic [1:0] ALU_bsel,
  output logic [1:0] result_sel,
  output logic [3:0] ALU_control,
  output logic [1:0] ximm_sel,
  output logic       instr_done,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_REG   = 2'b10;

  localparam logic [1:0] B_REG   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [1:0] R_ALUOUT = 2'b00;
  localparam logic [1:0] R_DATA   = 2'b01;
  localparam logic [1:0] R_ALURES = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic is_lw, is_sw, is_r, is_i;
  logic is_beq, is_jal, is_legal;

  logic       sra_i;
  logic [3:0] alu_r, alu_i;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_beq   = (opcode == OP_BEQ);
    is_jal   = (opcode == OP_JAL);
    is_legal = is_lw | is_sw | is_r |
               is_i | is_beq | is_jal;
  end

  // Immediate format tracks the opcode in every
  // state so the datapath ximm is always valid.
  always_comb begin
    ximm_sel = 2'b00;
    unique case (1'b1)
      is_sw:   ximm_sel = 2'b01;
      is_beq:  ximm_sel = 2'b10;
      is_jal:  ximm_sel = 2'b11;
      default: ximm_sel = 2'b00;
    endcase
  end

  // funct3 011 (sltu) folds onto slt.
  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLT;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // I-type bit 30 is immediate data except for
  // shifts, where it selects srai.
  always_comb begin
    sra_i = funct7b5 & (funct3 == 3'b101);
    alu_r = alu_dec(funct3, funct7b5);
    alu_i = alu_dec(funct3, sra_i);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_r:         state_d = S_EXEC_R;
          is_i:         state_d = S_EXEC_I;
          is_beq:       state_d = S_BEQ;
          is_jal:       state_d = S_JAL;
          default:
            state_d = ILLEGAL_HALT ? S_HALT
                                   : S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = is_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PC_write      = 1'b0;
    adr_sel       = 1'b0;
    IR_write      = 1'b0;
    mem_wren      = 1'b0;
    regfile_wren  = 1'b0;
    ALU_asel      = A_PC;
    ALU_bsel      = B_REG;
    result_sel    = R_ALUOUT;
    ALU_control   = ALU_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      // PC <= PC + 4 straight from the ALU.
      S_FETCH: begin
        IR_write   = 1'b1;
        PC_write   = 1'b1;
        ALU_bsel   = B_FOUR;
        result_sel = R_ALURES;
      end
      // Speculatively latch old_PC + imm into
      // ALUOut as the branch / jump target.
      S_DECODE: begin
        ALU_asel      = A_OLDPC;
        ALU_bsel      = B_IMM;
        illegal_instr = ~is_legal;
      end
      S_MEMADR: begin
        ALU_asel = A_REG;
        ALU_bsel = B_IMM;
      end
      S_MEMREAD: begin
        adr_sel = 1'b1;
      end
      S_MEMWB: begin
        result_sel   = R_DATA;
        regfile_wren = 1'b1;
        instr_done   = 1'b1;
      end
      S_MEMWRITE: begin
        adr_sel    = 1'b1;
        mem_wren   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_R: begin
        ALU_asel    = A_REG;
        ALU_control = alu_r;
      end
      S_EXEC_I: begin
        ALU_asel    = A_REG;
        ALU_bsel    = B_IMM;
        ALU_control = alu_i;
      end
      S_ALUWB: begin
        regfile_wren = 1'b1;
        instr_done   = 1'b1;
      end
      // Compare rs1 - rs2; the target already
      // sits in ALUOut from DECODE.
      S_BEQ: begin
        ALU_asel    = A_REG;
        ALU_control = ALU_SUB;
        PC_write    = Z;
        instr_done  = 1'b1;
      end
      // PC <= target in ALUOut while the ALU
      // forms old_PC + 4 for the link write.
      S_JAL: begin
        ALU_asel = A_OLDPC;
        ALU_bsel = B_FOUR;
        PC_write = 1'b1;
      end
      S_HALT: begin
      end
      default: begin
      end
    endcase

    // Reset kills all writes and parks the
    // selects at their FETCH values.
    if (reset) begin
      PC_write      = 1'b0;
      adr_sel       = 1'b0;
      IR_write      = 1'b0;
      mem_wren      = 1'b0;
      regfile_wren  = 1'b0;
      ALU_asel      = A_PC;
      ALU_bsel      = B_FOUR;
      result_sel    = R_ALURES;
      ALU_control   = ALU_ADD;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule
